// File: rtl/regibank_wrctrl_pkg.sv
// Shared constants and helpers for the register-bank write-port controller
// and its arbiter. Optional bypass path: REGIBANK_WRCTRL_BYPASS_EN.
package regibank_wrctrl_pkg;

  localparam int WR_SRC_EXEC  = 0;
  localparam int WR_SRC_MEM   = 1;
  localparam int WR_SRC_DBG   = 2;
  localparam int WR_SRC_TOTAL = 3;

  // Starvation counters need one bit beyond clog2 so the limit itself is representable.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/regibank_wrarb.sv
// Combinational arbiter: starved entries (lowest index first) beat the fixed
// memaccess > executor > debug order. Produces a one-hot grant over full entries.
module regibank_wrarb
  import regibank_wrctrl_pkg::*;
#(
  parameter int starve_limit = 4,
  parameter int cntw         = cnt_width(starve_limit)
) (
  input  logic [WR_SRC_TOTAL-1:0]      full,
  input  logic [WR_SRC_TOTAL*cntw-1:0] cnt,
  output logic [WR_SRC_TOTAL-1:0]      grant
);

  logic [WR_SRC_TOTAL-1:0] starved;

  always_comb begin
    starved = '0;
    for (int i = 0; i < WR_SRC_TOTAL; i++) begin
      starved[i] = full[i] && (cnt[i*cntw +: cntw] >= cntw'(starve_limit));
    end
  end

  always_comb begin
    grant = '0;
    if (|starved) begin
      if (starved[WR_SRC_EXEC])     grant[WR_SRC_EXEC] = 1'b1;
      else if (starved[WR_SRC_MEM]) grant[WR_SRC_MEM]  = 1'b1;
      else                          grant[WR_SRC_DBG]  = 1'b1;
    end else if (full[WR_SRC_MEM]) begin
      grant[WR_SRC_MEM] = 1'b1;
    end else if (full[WR_SRC_EXEC]) begin
      grant[WR_SRC_EXEC] = 1'b1;
    end else if (full[WR_SRC_DBG]) begin
      grant[WR_SRC_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/regibank_wrctrl.sv
// Write-port controller for the integer register bank: one holding register per
// source, arbitrated onto a registered write port; x0 writes are dropped.
// Optional macro REGIBANK_WRCTRL_BYPASS_EN forwards a lone request when all holding registers are empty.
module regibank_wrctrl
  import regibank_wrctrl_pkg::*;
#(
  parameter int abits        = 6,
  parameter int dwidth       = 64,
  parameter int tagw         = 3,
  parameter int starve_limit = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [WR_SRC_TOTAL-1:0]        i_req_valid,
  input  logic [WR_SRC_TOTAL*abits-1:0]  i_req_addr,
  input  logic [WR_SRC_TOTAL*dwidth-1:0] i_req_data,
  input  logic [WR_SRC_TOTAL*tagw-1:0]   i_req_tag,
  output logic [WR_SRC_TOTAL-1:0]        o_req_ready,
  output logic                           o_wena,
  output logic [abits-1:0]               o_waddr,
  output logic [dwidth-1:0]              o_wdata,
  output logic [tagw-1:0]                o_wtag,
  output logic [WR_SRC_TOTAL-1:0]        o_pending,
  output logic                           o_busy
);

  localparam int cntw = cnt_width(starve_limit);

  typedef struct packed {
    logic              full;
    logic [abits-1:0]  addr;
    logic [dwidth-1:0] data;
    logic [tagw-1:0]   tag;
    logic [cntw-1:0]   cnt;
  } RegWrReqType;

  typedef struct packed {
    RegWrReqType [0:WR_SRC_TOTAL-1] arr;
    logic                           wena;
    logic [abits-1:0]               waddr;
    logic [dwidth-1:0]              wdata;
    logic [tagw-1:0]                wtag;
  } RegibankWrctrl_registers;

  localparam RegibankWrctrl_registers R_RESET = '0;

  RegibankWrctrl_registers r, rin;

  logic [WR_SRC_TOTAL-1:0]      full;
  logic [WR_SRC_TOTAL*cntw-1:0] cnt_flat;
  logic [WR_SRC_TOTAL-1:0]      grant;
  logic [WR_SRC_TOTAL-1:0]      ready;
  logic [WR_SRC_TOTAL-1:0]      accept;
  logic [WR_SRC_TOTAL-1:0]      byp;
  logic                         sel_vld;
  logic [abits-1:0]             sel_addr;
  logic [dwidth-1:0]            sel_data;
  logic [tagw-1:0]              sel_tag;

  function automatic logic [cntw-1:0] cnt_sat_inc(input logic [cntw-1:0] c);
    return (&c) ? c : c + cntw'(1);
  endfunction

  always_comb begin
    full     = '0;
    cnt_flat = '0;
    for (int i = 0; i < WR_SRC_TOTAL; i++) begin
      full[i]                  = r.arr[i].full;
      cnt_flat[i*cntw +: cntw] = r.arr[i].cnt;
    end
  end

  regibank_wrarb #(
    .starve_limit(starve_limit),
    .cntw        (cntw)
  ) u_arb (
    .full (full),
    .cnt  (cnt_flat),
    .grant(grant)
  );

  assign ready  = ~full | grant;
  assign accept = i_req_valid & ready;

`ifdef REGIBANK_WRCTRL_BYPASS_EN
  // Only an idle bank may be bypassed, so the bypass never races a granted entry.
  always_comb begin
    byp = '0;
    if (!(|full)) begin
      if (i_req_valid[WR_SRC_MEM])       byp[WR_SRC_MEM]  = 1'b1;
      else if (i_req_valid[WR_SRC_EXEC]) byp[WR_SRC_EXEC] = 1'b1;
      else if (i_req_valid[WR_SRC_DBG])  byp[WR_SRC_DBG]  = 1'b1;
    end
  end
`else
  assign byp = '0;
`endif

  always_comb begin
    rin      = r;
    sel_vld  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < WR_SRC_TOTAL; i++) begin
      if (grant[i]) begin
        sel_vld  = 1'b1;
        sel_addr = r.arr[i].addr;
        sel_data = r.arr[i].data;
        sel_tag  = r.arr[i].tag;
      end else if (byp[i]) begin
        sel_vld  = 1'b1;
        sel_addr = i_req_addr[i*abits +: abits];
        sel_data = i_req_data[i*dwidth +: dwidth];
        sel_tag  = i_req_tag[i*tagw +: tagw];
      end

      // A refill in the grant cycle overrides the clear.
      if (accept[i] && !byp[i]) begin
        rin.arr[i].full = 1'b1;
        rin.arr[i].addr = i_req_addr[i*abits +: abits];
        rin.arr[i].data = i_req_data[i*dwidth +: dwidth];
        rin.arr[i].tag  = i_req_tag[i*tagw +: tagw];
      end else if (grant[i]) begin
        rin.arr[i].full = 1'b0;
      end

      rin.arr[i].cnt = (full[i] && !grant[i]) ? cnt_sat_inc(r.arr[i].cnt) : '0;
    end

    rin.wena = 1'b0;
    if (sel_vld && (sel_addr != '0)) begin
      rin.wena  = 1'b1;
      rin.waddr = sel_addr;
      rin.wdata = sel_data;
      rin.wtag  = sel_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r <= R_RESET;
    else       r <= rin;
  end

  assign o_req_ready = ready;
  assign o_wena      = r.wena;
  assign o_waddr     = r.waddr;
  assign o_wdata     = r.wdata;
  assign o_wtag      = r.wtag;
  assign o_pending   = full;
  assign o_busy      = (|full) | r.wena;

endmodule

// File: tb/tb_regibank_wrctrl.sv
// Directed bench for regibank_wrctrl (default build, REGIBANK_WRCTRL_BYPASS_EN undefined).
module tb_regibank_wrctrl;

  localparam int AB = 6;
  localparam int DW = 64;
  localparam int TW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      valid;
  logic [3*AB-1:0] addr;
  logic [3*DW-1:0] data;
  logic [3*TW-1:0] tag;
  logic [2:0]      ready;
  logic            wena;
  logic [AB-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [TW-1:0]   wtag;
  logic [2:0]      pending;
  logic            busy;

  int vectors    = 0;
  int miscompares = 0;

  regibank_wrctrl #(
    .abits(AB), .dwidth(DW), .tagw(TW), .starve_limit(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(valid),
    .i_req_addr (addr),
    .i_req_data (data),
    .i_req_tag  (tag),
    .o_req_ready(ready),
    .o_wena     (wena),
    .o_waddr    (waddr),
    .o_wdata    (wdata),
    .o_wtag     (wtag),
    .o_pending  (pending),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input logic v, input logic [AB-1:0] a,
                         input logic [DW-1:0] d, input logic [TW-1:0] t);
    valid[s]          = v;
    addr[s*AB +: AB]  = a;
    data[s*DW +: DW]  = d;
    tag[s*TW +: TW]   = t;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AB-1:0] starve_seq [6];
    starve_seq = '{6'd10, 6'd10, 6'd10, 6'd10, 6'd11, 6'd7};

    rst = 1'b1; valid = '0; addr = '0; data = '0; tag = '0;

    // Reset held with every source valid
    set_req(0, 1'b1, 6'd1, 64'h11, 3'd1);
    set_req(1, 1'b1, 6'd2, 64'h22, 3'd2);
    set_req(2, 1'b1, 6'd3, 64'h33, 3'd3);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_wena", 64'(wena), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_ready", 64'(ready), 64'b111);
    end
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    rst = 1'b0; valid = '0;
    tick();
    chk("post_rst_wena", 64'(wena), 64'd0);
    chk("post_rst_pending", 64'(pending), 64'd0);
    tick();
    chk("post_rst_wena2", 64'(wena), 64'd0);

    // Single executor write
    set_req(0, 1'b1, 6'd5, 64'h1234, 3'd2);
    #1 chk("single_ready", 64'(ready[0]), 64'd1);
    tick();
    valid = '0;
    chk("single_pending", 64'(pending), 64'b001);
    chk("single_wena_early", 64'(wena), 64'd0);
    chk("single_busy", 64'(busy), 64'd1);
    tick();
    chk("single_wena", 64'(wena), 64'd1);
    chk("single_waddr", 64'(waddr), 64'd5);
    chk("single_wdata", wdata, 64'h1234);
    chk("single_wtag", 64'(wtag), 64'd2);
    chk("single_pending_clr", 64'(pending), 64'd0);
    tick();
    chk("single_wena_once", 64'(wena), 64'd0);
    chk("single_waddr_hold", 64'(waddr), 64'd5);
    chk("single_idle", 64'(busy), 64'd0);

    // Three sources in the same cycle: mem, exec, dbg order
    set_req(0, 1'b1, 6'd1, 64'h101, 3'd1);
    set_req(1, 1'b1, 6'd2, 64'h102, 3'd2);
    set_req(2, 1'b1, 6'd3, 64'h103, 3'd3);
    tick();
    valid = '0;
    #1 chk("tri_ready0", 64'(ready), 64'b010);
    chk("tri_pending0", 64'(pending), 64'b111);
    tick();
    chk("tri_w1_addr", 64'(waddr), 64'd2);
    chk("tri_w1_data", wdata, 64'h102);
    chk("tri_pending1", 64'(pending), 64'b101);
    chk("tri_ready1", 64'(ready), 64'b011);
    tick();
    chk("tri_w2_wena", 64'(wena), 64'd1);
    chk("tri_w2_addr", 64'(waddr), 64'd1);
    chk("tri_ready2", 64'(ready), 64'b111);
    tick();
    chk("tri_w3_wena", 64'(wena), 64'd1);
    chk("tri_w3_addr", 64'(waddr), 64'd3);
    chk("tri_w3_tag", 64'(wtag), 64'd3);
    chk("tri_pending3", 64'(pending), 64'd0);
    tick();
    chk("tri_done", 64'(wena), 64'd0);

    // Starvation: mem and exec hammer, debug captured once
    set_req(0, 1'b1, 6'd11, 64'hB0, 3'd0);
    set_req(1, 1'b1, 6'd10, 64'hA0, 3'd1);
    set_req(2, 1'b1, 6'd7, 64'h77, 3'd5);
    tick();
    valid[2] = 1'b0;
    #1 chk("starve_ready_exec", 64'(ready[0]), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("starve_wena_%0d", k), 64'(wena), 64'd1);
      chk($sformatf("starve_addr_%0d", k), 64'(waddr), 64'(starve_seq[k]));
    end
    chk("starve_dbg_data", wdata, 64'h77);
    chk("starve_pending", 64'(pending), 64'b011);
    valid = '0;
    tick();
    chk("starve_drain_mem", 64'(waddr), 64'd10);
    tick();
    chk("starve_drain_exec", 64'(waddr), 64'd11);
    tick();
    chk("starve_idle_wena", 64'(wena), 64'd0);
    chk("starve_idle_pending", 64'(pending), 64'd0);

    // x0 write is consumed without a bank write
    set_req(1, 1'b1, 6'd0, 64'hFF, 3'd4);
    tick();
    valid = '0;
    chk("x0_pending", 64'(pending), 64'b010);
    tick();
    chk("x0_consumed", 64'(pending), 64'd0);
    chk("x0_wena", 64'(wena), 64'd0);
    chk("x0_waddr_hold", 64'(waddr), 64'd11);
    tick();
    chk("x0_wena_after", 64'(wena), 64'd0);

    // Reset while three entries are pending
    set_req(0, 1'b1, 6'd4, 64'h44, 3'd1);
    set_req(1, 1'b1, 6'd5, 64'h55, 3'd2);
    set_req(2, 1'b1, 6'd6, 64'h66, 3'd3);
    tick();
    valid = '0;
    chk("midrst_pending_before", 64'(pending), 64'b111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_wena", 64'(wena), 64'd0);
    chk("midrst_waddr", 64'(waddr), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst_no_write_%0d", k), 64'(wena), 64'd0);
    end

    // Back-to-back executor writes, one per cycle
    set_req(0, 1'b1, 6'd20, 64'h200, 3'd1);
    tick();
    set_req(0, 1'b1, 6'd21, 64'h210, 3'd2);
    tick();
    chk("b2b_w0", 64'(waddr), 64'd20);
    chk("b2b_ready", 64'(ready[0]), 64'd1);
    set_req(0, 1'b1, 6'd22, 64'h220, 3'd3);
    tick();
    chk("b2b_w1", 64'(waddr), 64'd21);
    chk("b2b_w1_data", wdata, 64'h210);
    valid = '0;
    tick();
    chk("b2b_w2", 64'(waddr), 64'd22);
    chk("b2b_w2_wena", 64'(wena), 64'd1);
    tick();
    chk("b2b_end", 64'(wena), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
